usb_bit_stuffer: RTL and testbench

- Serial USB transmit stage placed directly downstream of the packet serializer, which muxes the PID, address and crc5 serial output into one bit stream.
- Inserts a 0 after every run of MAX_ONES consecutive 1s, per USB bit-stuffing rules.
- Stalls the upstream source for one cycle per inserted bit.
- Feeds the NRZI encoder. Also keeps a per-packet count of stuffed bits for debug.

---
 rtl/usb_pkg.sv | 13 +
 rtl/usb_bit_stuffer_ones_run_counter.sv | 24 ++
 rtl/usb_bit_stuffer.sv | 110 +++++++++++
 tb/tb_usb_bit_stuffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types for the USB serial transmit path.
// Holds the bit-stuffer state encoding and the standard run length.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    STUFF
  } stuff_state_t;

  localparam int USB_MAX_ONES = 6;

endpackage

// File: rtl/usb_bit_stuffer_ones_run_counter.sv
// Saturating up-counter with synchronous clear and count enable; 1-cycle update.
// No backpressure: clear wins over enable, and the count holds at MAX.
module ones_run_counter #(
  parameter int             W   = 4,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_bit_stuffer.sv
// USB bit stuffer: inserts a 0 after MAX_ONES consecutive 1s; registered outputs, 1-cycle latency.
// Backpressure: stall is high for the single STUFF cycle; input is ignored while stalled.
module usb_bit_stuffer
  import usb_pkg::*;
#(
  parameter int MAX_ONES = USB_MAX_ONES,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             stall,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic [CNT_W-1:0] stuff_cnt
);

  localparam int OW = $clog2(MAX_ONES + 1);

  stuff_state_t  state;
  logic          pending_last;
  logic [OW-1:0] ones_cnt;
  logic          in_stuff;
  logic          accept;
  logic          run_done;
  logic          run_clr;
  logic          run_en;
  logic          cnt_clr;

  assign in_stuff = (state == STUFF);
  assign stall    = in_stuff;
  assign busy     = (state != IDLE);
  assign accept   = in_valid && !in_stuff;

  // This accepted 1 completes the run, so a stuffed 0 must follow it.
  assign run_done = accept && in_bit && (ones_cnt == OW'(MAX_ONES - 1));

  // A run survives gaps; it ends on a 0, a stuffed 0, or a packet end.
  assign run_en  = accept && in_bit;
  assign run_clr = (accept && !in_bit) || in_stuff || (accept && in_last && !run_done);
  assign cnt_clr = accept && (state == IDLE);

  ones_run_counter #(
    .W   (OW),
    .MAX (OW'(MAX_ONES))
  ) u_run_cnt (
    .clk (clk),
    .rst (rst),
    .clr (run_clr),
    .en  (run_en),
    .cnt (ones_cnt)
  );

  ones_run_counter #(
    .W   (CNT_W),
    .MAX ('1)
  ) u_stuff_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (in_stuff),
    .cnt (stuff_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending_last <= 1'b0;
      out_bit      <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      case (state)
        IDLE, PASS: begin
          if (accept) begin
            out_bit   <= in_bit;
            out_valid <= 1'b1;
            if (run_done) begin
              // The packet end, if any, moves onto the stuffed 0.
              state        <= STUFF;
              pending_last <= in_last;
            end else if (in_last) begin
              state    <= IDLE;
              out_last <= 1'b1;
            end else begin
              state <= PASS;
            end
          end
        end
        STUFF: begin
          out_bit      <= 1'b0;
          out_valid    <= 1'b1;
          out_last     <= pending_last;
          pending_last <= 1'b0;
          state        <= pending_last ? IDLE : PASS;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_bit_stuffer.sv
// Directed and randomized checks of usb_bit_stuffer against a stream-level stuffing model.
module tb_usb_bit_stuffer;

  localparam int MAX = 6;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_bit;
  logic          in_valid;
  logic          in_last;
  logic          stall;
  logic          out_bit;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic [CW-1:0] stuff_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0] obs_q[$];
  logic [1:0] exp_q[$];
  logic       pkt[$];

  usb_bit_stuffer #(
    .MAX_ONES (MAX),
    .CNT_W    (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .stall     (stall),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .stuff_cnt (stuff_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic b, input logic v, input logic l);
    in_bit   = b;
    in_valid = v;
    in_last  = l;
    @(negedge clk);
  endtask

  task automatic collect();
    if (out_valid) obs_q.push_back({out_last, out_bit});
  endtask

  task automatic chk_out(input string tag, input logic b, input logic v, input logic l);
    chk({tag, "_valid"}, int'(out_valid), int'(v));
    if (v) chk({tag, "_bit"}, int'(out_bit), int'(b));
    chk({tag, "_last"}, int'(out_last), int'(l));
  endtask

  initial begin
    int  k;
    int  cyc;
    int  stalls;
    int  n;
    int  run;
    int  st;
    logic s;
    logic v;
    logic lb;

    rst = 1'b1; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stall", int'(stall), 0);
    chk("rst_cnt", int'(stuff_cnt), 0);
    rst = 1'b0;
    step(0, 0, 0);

    // Reset mid-packet while in the stuffing cycle with a nonzero stuff count.
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    step(1, 1, 0);
    chk("rm_cnt1", int'(stuff_cnt), 1);
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    chk("rm_stall_pre", int'(stall), 1);
    rst = 1'b1;
    step(0, 0, 0);
    chk_out("rm_a", 0, 0, 0);
    chk("rm_a_stall", int'(stall), 0);
    chk("rm_a_busy", int'(busy), 0);
    chk("rm_a_cnt", int'(stuff_cnt), 0);
    step(1, 1, 0);
    chk_out("rm_b", 0, 0, 0);
    chk("rm_b_busy", int'(busy), 0);
    rst = 1'b0;
    step(0, 0, 0);

    // Seven 1s, last on the seventh.
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0);
      chk_out("s7_one", 1, 1, 0);
      chk("s7_stall", int'(stall), (i == 5) ? 1 : 0);
    end
    step(1, 1, 1);
    chk_out("s7_stuff", 0, 1, 0);
    chk("s7_stall_end", int'(stall), 0);
    step(1, 1, 1);
    chk_out("s7_final", 1, 1, 1);
    step(0, 0, 0);
    chk("s7_busy", int'(busy), 0);
    chk("s7_cnt", int'(stuff_cnt), 1);

    // Packet whose final bit completes a run: last moves onto the stuffed 0.
    step(0, 1, 0);
    chk_out("lt_zero", 0, 1, 0);
    chk("lt_cnt_clr", int'(stuff_cnt), 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 1, (i == 5));
      chk_out("lt_one", 1, 1, 0);
    end
    chk("lt_stall", int'(stall), 1);
    chk("lt_busy", int'(busy), 1);
    step(0, 0, 0);
    chk_out("lt_stuff", 0, 1, 1);
    chk("lt_busy_fall", int'(busy), 0);
    chk("lt_cnt", int'(stuff_cnt), 1);
    step(0, 0, 0);
    chk_out("lt_after", 0, 0, 0);

    // Five 1s then 0, three times: never stuffs.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        lb = (r == 2) && (i == 5);
        step((i < 5), 1, lb);
        chk_out("f5", (i < 5), 1, lb);
        chk("f5_stall", int'(stall), 0);
      end
    end
    chk("f5_cnt", int'(stuff_cnt), 0);
    step(0, 0, 0);

    // Run continues across gaps.
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0);
      chk("gap_valid", int'(out_valid), 0);
      chk("gap_stall", int'(stall), 0);
    end
    for (int i = 0; i < 3; i++) step(1, 1, 0);
    chk("gap_stall_on", int'(stall), 1);
    step(0, 1, 1);
    chk_out("gap_stuff", 0, 1, 0);
    step(0, 1, 1);
    chk_out("gap_final", 0, 1, 1);
    chk("gap_cnt", int'(stuff_cnt), 1);
    step(0, 0, 0);

    // Twelve 1s: two stuffs, then a new packet clears the count.
    obs_q.delete();
    stalls = 0;
    k = 0;
    cyc = 0;
    while (k < 12 && cyc < 100) begin
      s = stall;
      step(1, 1, (k == 11));
      collect();
      cyc++;
      if (s) stalls++;
      else k++;
    end
    chk("t12_timeout", int'(cyc < 100), 1);
    if (stall) stalls++;
    step(0, 0, 0);
    collect();
    chk("t12_stalls", stalls, 2);
    chk("t12_len", obs_q.size(), 14);
    for (int i = 0; i < 14 && i < obs_q.size(); i++)
      chk("t12_out", int'(obs_q[i]), int'({(i == 13), (i % 7 != 6)}));
    chk("t12_cnt", int'(stuff_cnt), 2);
    step(0, 1, 0);
    chk("t12_newpkt_cnt", int'(stuff_cnt), 0);
    step(1, 1, 1);
    chk_out("t12_newpkt_end", 1, 1, 1);
    step(0, 0, 0);

    // Randomized packets and gaps checked against the stuffing model.
    obs_q.delete();
    exp_q.delete();
    for (int p = 0; p < 40; p++) begin
      pkt.delete();
      n = (p == 0) ? 100 : $urandom_range(2, 24);
      for (int i = 0; i < n; i++) pkt.push_back((p == 0) ? 1'b1 : ($urandom_range(0, 7) < 6));
      run = 0;
      st = 0;
      for (int i = 0; i < n; i++) begin
        lb = (i == n - 1);
        run = pkt[i] ? run + 1 : 0;
        if (run == MAX) begin
          exp_q.push_back({1'b0, pkt[i]});
          exp_q.push_back({lb, 1'b0});
          run = 0;
          st++;
        end else begin
          exp_q.push_back({lb, pkt[i]});
        end
      end
      k = 0;
      cyc = 0;
      while (k < n && cyc < 2000) begin
        if (!stall) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom_range(0, 1));
            in_last  = 1'($urandom_range(0, 1));
          end else begin
            in_valid = 1'b1;
            in_bit   = pkt[k];
            in_last  = (k == n - 1);
          end
        end
        s = stall;
        v = in_valid;
        @(negedge clk);
        collect();
        cyc++;
        if (v && !s) k++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      while (busy && cyc < 2000) begin
        @(negedge clk);
        collect();
        cyc++;
      end
      chk("rnd_timeout", int'(cyc < 2000), 1);
      chk("rnd_cnt", int'(stuff_cnt), (st > 15) ? 15 : st);
    end
    chk("rnd_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("rnd_out", int'(obs_q[i]), int'(exp_q[i]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
